seq_divider: RTL and testbench

- Sequential restoring unsigned divider. It is the inverse operation of the team's combinational array multiplier.
- Computes quotient and remainder of WIDTH-bit operands, one quotient bit per clock.
- Uses a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic lab datapath, so that multiply/divide round-trips can be checked (p = q*b + r).

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_div_step.sv | 51 +++++
 rtl/seq_divider_full_adder.sv | 16 +
 rtl/seq_divider.sv | 99 +++++++++
 tb/tb_seq_divider.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

    // Default operand/result width; legal range is 2..16.
    localparam int unsigned DEFAULT_WIDTH = 4;

    // FSM encoding; 2'd3 is unreachable and recovers to idle.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// Combinational single restoring-division step: shift {R,Q} left by one,
// trial-subtract B, keep the difference and set the quotient bit if it is
// non-negative, otherwise restore.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    // The partial remainder is always < div, so its top bit is always zero and
    // only WIDTH bits are carried between steps; the trial subtraction still
    // runs WIDTH+1 bits wide.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   div_inv;
    logic [WIDTH:0]   diff;
    logic [WIDTH+1:0] carry;
    logic             nonneg;

    // Shifted remainder and inverted divisor feeding the subtractor.
    always_comb begin
        rem_sh  = {rem, quo[WIDTH-1]};
        div_inv = ~{1'b0, div};
    end

    assign carry[0] = 1'b1;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        full_adder u_fa (
            .a   (rem_sh[i]),
            .b   (div_inv[i]),
            .cin (carry[i]),
            .sum (diff[i]),
            .cout(carry[i+1])
        );
    end

    // Sign bit clear and no borrow out agree while rem < div; requiring both
    // keeps a quotient bit from being set if that invariant were ever broken.
    always_comb begin
        nonneg   = ~diff[WIDTH] & carry[WIDTH+1];
        next_rem = nonneg ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        next_quo = {quo[WIDTH-2:0], nonneg};
    end

endmodule

// File: rtl/seq_divider_full_adder.sv
// One-bit full adder cell, the building block of the ripple subtractor.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain sum/carry equations.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock, with a
// start/busy/done handshake. Results are held until the next accepted start.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (r_reg),
        .quo     (q_reg),
        .div     (b_reg),
        .next_rem(step_rem),
        .next_quo(step_quo)
    );

    // FSM, iteration counter, working registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            r_reg       <= '0;
            q_reg       <= '0;
            b_reg       <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        if (divisor != '0) begin
                            b_reg       <= divisor;
                            q_reg       <= dividend;
                            r_reg       <= '0;
                            count       <= CW'(WIDTH - 1);
                            state       <= StCalc;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            div_by_zero <= 1'b0;
                        end else begin
                            // Division by zero resolves in a single edge.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            state       <= StDone;
                        end
                    end
                end
                StCalc: begin
                    r_reg <= step_rem;
                    q_reg <= step_quo;
                    if (count == '0) begin
                        state     <= StDone;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= step_quo;
                        remainder <= step_rem;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4): vector table, scoreboard of
// expected results, hand-written multi-cycle corner cases, exhaustive sweep.
module tb_seq_divider;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[11];
    int   n_cmp = 0;
    int   n_err = 0;

    seq_divider #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_model(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = W'(32'(a) / 32'(b));
            e.r   = W'(32'(a) % 32'(b));
            e.dbz = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Called just after the acceptance edge; waits for done and scores it.
    task automatic collect(input int exp_lat);
        vec_t e;
        int   waited = 0;
        while (!done && waited < 20) begin
            tick();
            waited++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(waited), 32'(exp_lat));
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("quotient", 32'(quotient), 32'(e.q));
            check("remainder", 32'(remainder), 32'(e.r));
            check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            check("busy_at_done", 32'(busy), 32'd0);
            if (!e.dbz) begin
                check("q_times_b_plus_r", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
                check("rem_lt_div", 32'(remainder < e.b), 32'd1);
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        push_model(a, b);
        tick();
        start = 1'b0;
        collect((b == 0) ? 0 : int'(W));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        tick();

        // Vector table: {a, b, q, r, dbz}
        vecs[0]  = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0};
        vecs[1]  = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
        vecs[2]  = '{4'd3,  4'd7,  4'd0,  4'd3, 1'b0};
        vecs[3]  = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
        vecs[4]  = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
        vecs[5]  = '{4'd14, 4'd4,  4'd3,  4'd2, 1'b0};
        vecs[6]  = '{4'd5,  4'd0,  4'd15, 4'd5, 1'b1};
        vecs[7]  = '{4'd9,  4'd2,  4'd4,  4'd1, 1'b0};
        vecs[8]  = '{4'd7,  4'd0,  4'd15, 4'd7, 1'b1};
        vecs[9]  = '{4'd15, 4'd2,  4'd7,  4'd1, 1'b0};
        vecs[10] = '{4'd8,  4'd8,  4'd1,  4'd0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            start    = 1'b1;
            dividend = vecs[i].a;
            divisor  = vecs[i].b;
            sb.push_back(vecs[i]);
            tick();
            start = 1'b0;
            collect(vecs[i].dbz ? 0 : int'(W));
        end

        // 13/3 cycle by cycle: busy high during cycles 1..W, done after edge W.
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        tick();
        start = 1'b0;
        check("lat_accept_busy", 32'(busy), 32'd1);
        check("lat_accept_done", 32'(done), 32'd0);
        for (int k = 1; k < int'(W); k++) begin
            tick();
            check("lat_mid_busy", 32'(busy), 32'd1);
            check("lat_mid_done", 32'(done), 32'd0);
        end
        tick();
        check("lat_end_busy", 32'(busy), 32'd0);
        check("lat_end_done", 32'(done), 32'd1);
        check("lat_end_q", 32'(quotient), 32'd4);
        check("lat_end_r", 32'(remainder), 32'd1);
        check("lat_end_dbz", 32'(div_by_zero), 32'd0);

        // Back-to-back 15/1 then 3/7 from DONE with no idle cycle.
        run_op(4'd15, 4'd1);
        start    = 1'b1;
        dividend = 4'd3;
        divisor  = 4'd7;
        push_model(4'd3, 4'd7);
        tick();
        start = 1'b0;
        check("b2b_done_drop", 32'(done), 32'd0);
        check("b2b_busy_rise", 32'(busy), 32'd1);
        collect(int'(W));

        // Divide by zero resolves in one edge, busy never rises.
        run_op(4'd5, 4'd0);

        // 14/4 with a 9/2 start pulse while busy: the pulse is ignored.
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd4;
        push_model(4'd14, 4'd4);
        tick();
        start = 1'b0;
        tick();
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd2;
        tick();
        start = 1'b0;
        collect(int'(W) - 2);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ignored_hold_done", 32'(done), 32'd1);
            check("ignored_hold_q", 32'(quotient), 32'd3);
        end

        // Asynchronous reset mid-operation aborts it.
        start    = 1'b1;
        dividend = 4'd12;
        divisor  = 4'd5;
        tick();
        start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_q", 32'(quotient), 32'd0);
        check("arst_r", 32'(remainder), 32'd0);
        check("arst_dbz", 32'(div_by_zero), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_done", 32'(done), 32'd0);
        run_op(4'd12, 4'd5);

        // Exhaustive sweep, b != 0.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(W'(a), W'(b));
            end
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
